// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: forwarding, load-use, redirect, memory-wait handling and watchdog.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             halted,
    output logic [1:0]       bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, IWAIT, DWAIT, HALT} state_t;

    localparam int unsigned     WC_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_t          state;
    logic [WC_W-1:0] wcnt;

    logic lwstall, dwait, iwait;
    logic row_halt, row_dwait, row_branch, row_lw, row_iwait;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    assign lwstall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign dwait   = MemReqM && !dmem_ready;
    assign iwait   = !imem_ready;

    // One-hot priority decode: exactly one row (or none) is active each cycle.
    assign row_halt   = (state == HALT);
    assign row_dwait  = !row_halt && dwait;
    assign row_branch = !row_halt && !dwait && PCSrcE;
    assign row_lw     = !row_halt && !dwait && !PCSrcE && lwstall;
    assign row_iwait  = !row_halt && !dwait && !PCSrcE && !lwstall && iwait;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (row_halt) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (row_dwait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (row_branch) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (row_lw) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (row_iwait) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end
    end

    // wcnt counts wait cycles already spent, so entering a wait state loads 1;
    // this makes HALT land on edge TIMEOUT for a wait that starts at cycle 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            wcnt    <= '0;
            halted  <= 1'b0;
            bus_err <= 2'b00;
        end else begin
            case (state)
                RUN: begin
                    if (row_dwait) begin
                        state <= DWAIT;
                        wcnt  <= WC_W'(1);
                    end else if (row_iwait) begin
                        state <= IWAIT;
                        wcnt  <= WC_W'(1);
                    end
                end
                IWAIT: begin
                    if (row_dwait) begin
                        state <= DWAIT;
                        wcnt  <= '0;
                    end else if (!row_iwait) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else if (wcnt == WC_LAST) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        bus_err <= 2'b01;
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
                end
                DWAIT: begin
                    if (!row_dwait) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else if (wcnt == WC_LAST) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        bus_err <= 2'b10;
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
                end
                default: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && !row_halt)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (FlushD || FlushE)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT=4); counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, imem_ready, dmem_ready;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE, bus_err;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       ctl;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.TIMEOUT(4), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .halted(halted), .bus_err(bus_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemReqM = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (bus_err !== 2'b00) begin errors++; $display("FAIL reset_bus_err got=%b exp=00", bus_err); end
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL reset_ctl got=%b exp=0000000", ctl); end
        checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_forwarding();
        idle();
        RdM = 5; RegWriteM = 1'b1; RdW = 5; RegWriteW = 1'b1; Rs1E = 5; Rs2E = 7;
        #1;
        checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_mem_prio got=%b exp=10", ForwardAE); end
        checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwd_b_none got=%b exp=00", ForwardBE); end
        RdM = 0; Rs2E = 5;
        #1;
        checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_rdm_zero got=%b exp=01", ForwardAE); end
        checks++; if (ForwardBE !== 2'b01) begin errors++; $display("FAIL fwd_b_wb got=%b exp=01", ForwardBE); end
        RdM = 5; RegWriteM = 1'b0; RdW = 0;
        #1;
        checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_disabled got=%b exp=00", ForwardAE); end
        RegWriteM = 1'b1; Rs1E = 0; Rs2E = 0; RdM = 0;
        #1;
        checks++; if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin errors++; $display("FAIL fwd_x0 got=%b/%b exp=00/00", ForwardAE, ForwardBE); end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        ResultSrcE0 = 1'b1; RdE = 3; Rs2D = 3; Rs1D = 9;
        #1;
        checks++; if (ctl !== 7'b1100010) begin errors++; $display("FAIL lw_stall got=%b exp=1100010", ctl); end
        PCSrcE = 1'b1;
        #1;
        checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL lw_branch got=%b exp=0000110", ctl); end
        PCSrcE = 1'b0; RdE = 0; Rs2D = 0;
        #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL lw_rd_x0 got=%b exp=0000000", ctl); end
        RdE = 9; imem_ready = 1'b0;
        #1;
        checks++; if (ctl !== 7'b1100010) begin errors++; $display("FAIL lw_over_iwait got=%b exp=1100010", ctl); end
        idle();
        #1;
    endtask

    task automatic test_imem_wait();
        do_reset();
        for (int burst = 0; burst < 2; burst++) begin
            imem_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
                #1;
                checks++; if (ctl !== 7'b1000100) begin errors++; $display("FAIL iwait_ctl burst=%0d cyc=%0d got=%b exp=1000100", burst, c, ctl); end
                step();
            end
            imem_ready = 1'b1;
            #1;
            checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL iwait_release got=%b exp=0000000", ctl); end
            step();
            step();
            checks++; if (halted !== 1'b0) begin errors++; $display("FAIL iwait_halted burst=%0d got=%b exp=0", burst, halted); end
        end
    endtask

    task automatic test_dmem_timeout();
        do_reset();
        MemReqM = 1'b1; dmem_ready = 1'b0; PCSrcE = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1111001) begin errors++; $display("FAIL dwait_ctl got=%b exp=1111001", ctl); end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (halted !== (k == 4)) begin errors++; $display("FAIL dwait_halt_edge%0d got=%b exp=%b", k, halted, (k == 4)); end
        end
        checks++; if (bus_err !== 2'b10) begin errors++; $display("FAIL timeout_bus_err got=%b exp=10", bus_err); end
        checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL halt_ctl got=%b exp=1111000", ctl); end
        dmem_ready = 1'b1; PCSrcE = 1'b0;
        step();
        step();
        checks++; if (halted !== 1'b1 || bus_err !== 2'b10) begin errors++; $display("FAIL halt_sticky got=%b/%b exp=1/10", halted, bus_err); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0 || bus_err !== 2'b00) begin errors++; $display("FAIL async_rst got=%b/%b exp=0/00", halted, bus_err); end
        idle();
        step();
        rst = 1'b0;
    endtask

    task automatic test_boundary();
        do_reset();
        for (int burst = 0; burst < 2; burst++) begin
            MemReqM = 1'b1; dmem_ready = 1'b0;
            step();
            step();
            step();
            dmem_ready = 1'b1;
            #1;
            checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL boundary_release got=%b exp=0000000", ctl); end
            step();
            checks++; if (halted !== 1'b0) begin errors++; $display("FAIL boundary_halted burst=%0d got=%b exp=0", burst, halted); end
            MemReqM = 1'b0;
            step();
            checks++; if (FlushW !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL boundary_after got=%b/%b exp=0/0", FlushW, halted); end
        end
    endtask

    task automatic test_counters();
        do_reset();
        ResultSrcE0 = 1'b1; RdE = 3; Rs2D = 3;
        step();
        step();
        ResultSrcE0 = 1'b0; PCSrcE = 1'b1;
        step();
        idle();
        step();
`ifdef HAZARD_PERF_EN
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt got=%0d exp=2", stall_cnt); end
        checks++; if (flush_cnt !== 32'd3) begin errors++; $display("FAIL flush_cnt got=%0d exp=3", flush_cnt); end
`else
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", flush_cnt); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        test_reset();
        test_forwarding();
        test_load_use();
        test_imem_wait();
        test_dmem_timeout();
        test_boundary();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core: generates stall, flush and forwarding controls for the fetch/decode, decode/execute, execute/memory and memory/writeback pipeline registers. Resolves load-use hazards, taken-branch redirects and instruction/data memory wait states. Runs a watchdog FSM that halts the core on a memory that never responds. Sits beside the datapath; all pipeline registers take their stall/flush inputs from this block.

## Interface
- TIMEOUT, 16: consecutive wait cycles before a memory is declared dead (≥2).
- REG_W, 5: register-index width.
- CNT_W, 32: performance-counter width.

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  REG_W  source registers in decode
- Rs1E, Rs2E, RdE  in  REG_W  source/destination registers in execute
- ResultSrcE0  in  1  execute instruction is a load
- PCSrcE  in  1  taken branch/jump resolved in execute
- RdM, RdW  in  REG_W  destinations in memory/writeback
- RegWriteM, RegWriteW  in  1  register-write enables in memory/writeback
- MemReqM  in  1  memory stage issues a data access
- imem_ready  in  1  instruction at PCF is valid this cycle
- dmem_ready  in  1  data access completes this cycle
- StallF, StallD, StallE, StallM  out  1  hold the PC and the F/D, D/E and E/M registers
- FlushD, FlushE, FlushW  out  1  load a bubble (NOP, 0x00000013) into F/D, D/E and M/W
- ForwardAE, ForwardBE  out  2  00 regfile, 01 writeback result, 10 memory ALU result
- halted  out  1  core frozen by watchdog
- bus_err  out  2  00 none, 01 imem timeout, 10 dmem timeout
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- Forwarding, combinational: ForwardAE = 10 if RegWriteM and RdM≠0 and RdM==Rs1E; otherwise 01 if RegWriteW and RdW≠0 and RdW==Rs1E; otherwise 00. ForwardBE is identical using Rs2E. Memory stage takes priority.
- lwStall = ResultSrcE0 and RdE≠0 and (RdE==Rs1D or RdE==Rs2D).
- dwait = MemReqM and !dmem_ready. iwait = !imem_ready.
- Control outputs are combinational; the first matching row applies, and all unlisted outputs are 0:
  - 1. state HALT: StallF/D/E/M=1.
  - 2. dwait: StallF/D/E/M=1, FlushW=1. The whole pipe freezes and writeback drains a bubble.
  - 3. PCSrcE: FlushD=1, FlushE=1. This overrides lwStall and iwait; the PC takes the target.
  - 4. lwStall: StallF=1, StallD=1, FlushE=1.
  - 5. iwait: StallF=1, FlushD=1.
- FSM states: RUN, IWAIT, DWAIT, HALT, with a wait counter wcnt.
  - RUN → DWAIT when row 2 is active. RUN → IWAIT when row 5 is active.
  - DWAIT: wcnt increments each cycle. Returns to RUN and clears wcnt when dwait drops. Goes to HALT with bus_err=10 when wcnt==TIMEOUT-1 and dwait is still true.
  - IWAIT behaves the same, keyed on row 5 being active, with bus_err=01. A PCSrcE or dwait cycle during IWAIT clears wcnt; dwait moves the FSM to DWAIT.
  - HALT is terminal until rst. halted=1 and bus_err holds.

## Timing
- Reset: state RUN, wcnt=0, halted=0, bus_err=00, counters=0. Combinational outputs follow the inputs during reset.
- Halt timing: with dwait held from cycle 0, the FSM is in DWAIT from cycle 1 and reaches HALT at edge TIMEOUT. The core is therefore frozen for TIMEOUT cycles before halted rises.
- dmem_ready arriving in the same cycle that wcnt==TIMEOUT-1 counts as a completion; no halt occurs.
- PCSrcE during dwait has no effect until dwait clears. PCSrcE is held by the frozen D/E register, so it is not lost.
- rst asserted mid-wait or in HALT returns the block to RUN immediately (asynchronous).

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments every cycle StallF=1 and not HALT.
  - flush_cnt increments every cycle FlushD or FlushE=1.
  - Both wrap at 2^CNT_W and clear on reset.
- HAZARD_PERF_EN undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10. Same with RdM=0 → ForwardAE=01.
- Load-use: ResultSrcE0=1, RdE=3, Rs2D=3 → StallF=1, StallD=1, FlushE=1. Adding PCSrcE=1 → FlushD=1, FlushE=1, StallF=0.
- Imem wait: imem_ready=0 for 3 cycles → StallF=1 and FlushD=1 each cycle; FSM returns to RUN; halted stays 0.
- Dmem timeout with TIMEOUT=4: MemReqM=1, dmem_ready=0 held → halted=1 and bus_err=10 after edge 4. Subsequently dmem_ready=1 → still halted. Assert rst → halted=0, bus_err=00.
- Boundary: dmem_ready=1 on the cycle wcnt=3 (TIMEOUT=4) → no halt; returns to RUN; FlushW=0 afterwards.
- Counters (HAZARD_PERF_EN): 2 lwStall cycles plus 1 PCSrcE cycle → stall_cnt=2, flush_cnt=3. Without the macro → both read 0.
